mcu_raster_sequencer: RTL and testbench
=======================================

Name: mcu_raster_sequencer

Overview:
- Drives the select of the MCU construction mux and streams the selected MCU's pixels out in image raster order.
- Sits between the MCU block storage (MCUs in a MCU_COLS x MCU_ROWS grid, row-major index) and the downstream pixel consumer (display/frame writer).
- One frame per start pulse.
- Valid/ready output handshake with backpressure; the output register stage isolates the mux's combinational path.

Parameters:
- MCU_COLS, 7, MCUs per image row (image width = 8*MCU_COLS pixels)
- MCU_ROWS, 4, MCU rows (image height = 8*MCU_ROWS pixels)
- SEL_W, 11, width of mux select; MCU_COLS*MCU_ROWS-1 must fit
- PIX_W, 32, pixel word width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame; honoured only in IDLE
- abort  in  1  synchronous; terminates the frame and returns to IDLE
- sel  out  SEL_W  MCU select to mux: mcu_r*MCU_COLS + mcu_c
- mcu_in  in  8x8xPIX_W  mux output [row][col][bit], combinational from sel
- pix_data  out  PIX_W  registered pixel
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  consumer accepts when pix_valid && pix_ready
- pix_x  out  16  image column of pix_data
- pix_y  out  16  image row of pix_data
- sof  out  1  pix_data is pixel (0,0)
- eol  out  1  pix_data is last pixel of its image row
- eof  out  1  pix_data is the last pixel of the frame
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when the final pixel is accepted

Behaviour:
- Reset (async, any time, including mid-frame):
  - State goes to IDLE.
  - All counters, sel, pix_data, pix_x, pix_y, pix_valid, sof, eol, eof, busy and done are 0.
- Counters:
  - y in 0..8*MCU_ROWS-1; mcu_c in 0..MCU_COLS-1; x in 0..7.
  - x is innermost, then mcu_c, then y.
  - mcu_r = y>>3.
  - Mux indices: row = y[2:0], col = x.
- sel is registered from the counters. mcu_in must reflect the current sel in the same cycle.
- Load condition: load = (state==RUN) && (!pix_valid || pix_ready).
- On load:
  - pix_data <= mcu_in[y[2:0]][x].
  - pix_x <= mcu_c*8+x; pix_y <= y.
  - Flags are registered together with the data:
    - sof = (y==0 && mcu_c==0 && x==0).
    - eol = (mcu_c==MCU_COLS-1 && x==7).
    - eof = (eol && y==8*MCU_ROWS-1).
  - pix_valid <= 1; counters advance.
- If pix_valid && pix_ready && !load: pix_valid <= 0.
- pix_valid and pix_data hold stable while pix_valid && !pix_ready (no drop, no duplicate).
- FSM:
  - IDLE: counters and sel = 0. start -> RUN (busy=1 next cycle).
  - RUN: loads per the load condition. A load of the eof pixel -> DRAIN; counters wrap to 0.
  - DRAIN: no loads. eof pixel accepted -> IDLE, with done=1 for one cycle and busy=0 in that same cycle.
  - abort in RUN/DRAIN -> IDLE next cycle: pix_valid cleared, counters cleared, no done. abort has priority over load.
- Latency and throughput:
  - start at cycle T -> first pix_valid at T+2 (RUN entered T+1, load at T+1).
  - Throughput is 1 pixel/clk with pix_ready held high.
  - Frame of 8*MCU_COLS*8*MCU_ROWS pixels; default 1792.
- start while busy: ignored. start and abort in the same IDLE cycle: abort wins, stay IDLE.
- mcu_in must stay stable while busy; this is the caller's responsibility.

Optional Feature:
- Macro: MCU_SEQ_CLAMP_EN.
- Defined: pix_data is the loaded word treated as signed and clamped to 0..255, zero-extended to PIX_W (e.g. -5 -> 0, 300 -> 255, 77 -> 77). This is applied in the load path with no added latency.
- Undefined: the word passes through unmodified.

Test Plan:
- Reset: rst asserted mid-frame (pixel 500) -> all outputs 0 in the same cycle (async), IDLE; after release, start produces a full frame from pixel (0,0).
- Full frame: defaults, each mux MCU filled with pixel = sel*64+row*8+col, pix_ready=1 -> 1792 pixels, one per clk.
  - Pixel (x=8,y=0) has sel=1 and value 64.
  - Pixel (55,31) has sel=27 and value 27*64+63=1791, with eof=1.
  - eol at every x=55; done one cycle after eof is accepted.
- Backpressure: random pix_ready (50%) -> identical 1792-pixel sequence to the full-frame case; data stable while stalled; no loss or duplication.
- MCU boundary: MCU_COLS=2, MCU_ROWS=2 -> row 8 starts with sel=2; pixel (15,15) is the eof pixel with sel=3; 256 pixels total.
- Control corner cases:
  - abort at pixel 100 -> pix_valid=0 next cycle, no done.
  - start during busy is ignored.
  - start+abort in IDLE -> stays IDLE.
- MCU_SEQ_CLAMP_EN: mcu_in values -5, 300, 77 -> pix_data 0, 255, 77. Without the macro -> 0xFFFFFFFB, 300, 77.

Source files
------------

// File: rtl/mcu_raster_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_raster_sequencer_if
//  Description : Pixel stream bundle between the MCU raster sequencer and
//                the downstream pixel consumer (display / frame writer).
//                master : drives pixel word, coordinates, flags and valid
//                slave  : drives ready
//  Signals     : pix_data  [PIX_W] registered pixel word
//                pix_valid          pix_data valid
//                pix_ready          consumer accepts on pix_valid && pix_ready
//                pix_x/pix_y [16]   image column / row of pix_data
//                sof/eol/eof        first pixel / end of row / end of frame
//  Revision    : 1.0  initial release
// ============================================================================
interface mcu_raster_sequencer_if #(
    parameter int PIX_W = 32
);
    logic [PIX_W-1:0] pix_data;
    logic             pix_valid;
    logic             pix_ready;
    logic [15:0]      pix_x;
    logic [15:0]      pix_y;
    logic             sof;
    logic             eol;
    logic             eof;

    modport master (
        output pix_data, pix_valid, pix_x, pix_y, sof, eol, eof,
        input  pix_ready
    );

    modport slave (
        input  pix_data, pix_valid, pix_x, pix_y, sof, eol, eof,
        output pix_ready
    );
endinterface
`default_nettype wire

// File: rtl/mcu_raster_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_raster_sequencer
//  Description : Walks an MCU_COLS x MCU_ROWS grid of 8x8 MCUs in image
//                raster order, drives the select of the MCU construction mux
//                and streams the selected pixel out through a registered
//                valid/ready stage (one pixel per clock without backpressure).
//  Ports       : clk, rst      clock, asynchronous active-high reset
//                start         one-cycle frame start, honoured only in IDLE
//                abort         terminates the frame, back to IDLE
//                sel           registered MCU select (mcu_r*MCU_COLS+mcu_c)
//                mcu_in        mux output [row][col][bit] for the current sel
//                pix           pixel stream (mcu_raster_sequencer_if.master)
//                busy          high while RUN or DRAIN
//                done          one-cycle pulse after the eof pixel is taken
//  Option      : MCU_SEQ_CLAMP_EN - when defined, each loaded word is treated
//                as signed and clamped to 0..255 before registering.
//  Revision    : 1.0  initial release
// ============================================================================
module mcu_raster_sequencer #(
    parameter int MCU_COLS = 7,
    parameter int MCU_ROWS = 4,
    parameter int SEL_W    = 11,
    parameter int PIX_W    = 32
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          start,
    input  wire logic                          abort,
    output      logic [SEL_W-1:0]              sel,
    input  wire logic [7:0][7:0][PIX_W-1:0]    mcu_in,
    mcu_raster_sequencer_if.master             pix,
    output      logic                          busy,
    output      logic                          done
);

    // Counter widths; a single MCU column still needs a 1-bit counter.
    localparam int CW = (MCU_COLS > 1) ? $clog2(MCU_COLS) : 1;
    localparam int YW = $clog2(8 * MCU_ROWS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    logic [2:0]      x;
    logic [CW-1:0]   mcu_c;
    logic [YW-1:0]   y;

    logic [2:0]      x_n;
    logic [CW-1:0]   mcu_c_n;
    logic [YW-1:0]   y_n;
    logic            last_c;
    logic            last_y;
    logic            sof_now;
    logic            eol_now;
    logic            eof_now;
    logic            load;
    logic [PIX_W-1:0] raw_word;
    logic [PIX_W-1:0] load_word;

    function automatic logic [SEL_W-1:0] sel_of(input logic [YW-1:0]  yy,
                                                input logic [CW-1:0]  cc);
        sel_of = SEL_W'(yy >> 3) * SEL_W'(MCU_COLS) + SEL_W'(cc);
    endfunction

    assign last_c  = (mcu_c == CW'(MCU_COLS - 1));
    assign last_y  = (y == YW'(8 * MCU_ROWS - 1));
    assign sof_now = (y == '0) && (mcu_c == '0) && (x == 3'd0);
    assign eol_now = last_c && (x == 3'd7);
    assign eof_now = eol_now && last_y;

    // The output register is free when empty or being drained this cycle.
    assign load = (state == RUN) && (!pix.pix_valid || pix.pix_ready);

    // Next raster position: x innermost, then MCU column, then image row.
    // The eof position wraps every counter back to zero.
    always_comb begin
        x_n     = x + 3'd1;
        mcu_c_n = mcu_c;
        y_n     = y;
        if (x == 3'd7) begin
            if (last_c) begin
                mcu_c_n = '0;
                y_n     = last_y ? '0 : y + YW'(1);
            end else begin
                mcu_c_n = mcu_c + CW'(1);
            end
        end
    end

    // mcu_in already reflects the registered sel, so the word for the
    // current position is a pure index into the mux output.
    always_comb begin
        raw_word = mcu_in[y[2:0]][x];
`ifdef MCU_SEQ_CLAMP_EN
        if (raw_word[PIX_W-1]) begin
            load_word = '0;
        end else if (|raw_word[PIX_W-2:8]) begin
            load_word = PIX_W'(255);
        end else begin
            load_word = raw_word;
        end
`else
        load_word = raw_word;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            x             <= '0;
            mcu_c         <= '0;
            y             <= '0;
            sel           <= '0;
            pix.pix_data  <= '0;
            pix.pix_valid <= 1'b0;
            pix.pix_x     <= '0;
            pix.pix_y     <= '0;
            pix.sof       <= 1'b0;
            pix.eol       <= 1'b0;
            pix.eof       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((state != IDLE) && abort) begin
                // Abort beats any pending load; the frame is dropped silently.
                state         <= IDLE;
                x             <= '0;
                mcu_c         <= '0;
                y             <= '0;
                sel           <= '0;
                pix.pix_valid <= 1'b0;
                pix.sof       <= 1'b0;
                pix.eol       <= 1'b0;
                pix.eof       <= 1'b0;
                busy          <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (load) begin
                            pix.pix_data  <= load_word;
                            pix.pix_x     <= 16'({mcu_c, x});
                            pix.pix_y     <= 16'(y);
                            pix.sof       <= sof_now;
                            pix.eol       <= eol_now;
                            pix.eof       <= eof_now;
                            pix.pix_valid <= 1'b1;
                            x             <= x_n;
                            mcu_c         <= mcu_c_n;
                            y             <= y_n;
                            sel           <= sel_of(y_n, mcu_c_n);
                            if (eof_now) begin
                                state <= DRAIN;
                            end
                        end else if (pix.pix_valid && pix.pix_ready) begin
                            pix.pix_valid <= 1'b0;
                        end
                    end
                    DRAIN: begin
                        // Only the eof pixel can be pending here.
                        if (pix.pix_valid && pix.pix_ready) begin
                            pix.pix_valid <= 1'b0;
                            state         <= IDLE;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mcu_raster_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcu_raster_sequencer
//  Description : Scoreboard bench for mcu_raster_sequencer. A default-size
//                instance (7x4 MCUs) and a small instance (2x2 MCUs) are
//                driven from behavioural MCU memories; expected pixels are
//                generated in image raster order and checked by monitors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mcu_raster_sequencer;

    localparam int COLS  = 7;
    localparam int ROWS  = 4;
    localparam int W     = 8 * COLS;
    localparam int H     = 8 * ROWS;
    localparam int NPIX  = W * H;
    localparam int NMCU  = COLS * ROWS;
    localparam int COLS2 = 2;
    localparam int ROWS2 = 2;

    typedef struct packed {
        logic [31:0] d;
        logic [15:0] x;
        logic [15:0] y;
        logic        sof;
        logic        eol;
        logic        eof;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [10:0] sel;
    logic [7:0][7:0][31:0] mcu_in;
    logic busy;
    logic done;

    logic start2 = 1'b0;
    logic abort2 = 1'b0;
    logic [10:0] sel2;
    logic [7:0][7:0][31:0] mcu_in2;
    logic busy2;
    logic done2;

    logic [31:0] mem  [NMCU][8][8];
    logic [31:0] mem2 [COLS2*ROWS2][8][8];

    int   total = 0;
    int   bad   = 0;
    int   acc   = 0;
    bit   bp_en = 1'b0;
    pix_t q[$];
    pix_t q2[$];

    mcu_raster_sequencer_if #(.PIX_W(32)) ifc  ();
    mcu_raster_sequencer_if #(.PIX_W(32)) ifc2 ();

    mcu_raster_sequencer #(
        .MCU_COLS(COLS), .MCU_ROWS(ROWS), .SEL_W(11), .PIX_W(32)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .sel(sel), .mcu_in(mcu_in), .pix(ifc.master),
        .busy(busy), .done(done)
    );

    mcu_raster_sequencer #(
        .MCU_COLS(COLS2), .MCU_ROWS(ROWS2), .SEL_W(11), .PIX_W(32)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .sel(sel2), .mcu_in(mcu_in2), .pix(ifc2.master),
        .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    // Behavioural MCU construction mux.
    always_comb begin
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mcu_in[r][c] = mem[int'(sel) % NMCU][r][c];
    end

    always_comb begin
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mcu_in2[r][c] = mem2[int'(sel2) % (COLS2*ROWS2)][r][c];
    end

    // Consumer readiness: random when backpressure is enabled.
    initial ifc.pix_ready  = 1'b1;
    initial ifc2.pix_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        ifc.pix_ready = bp_en ? 1'($urandom % 2) : 1'b1;
    end

    function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef MCU_SEQ_CLAMP_EN
        if ($signed(w) < 0)        return 32'd0;
        else if ($signed(w) > 255) return 32'd255;
        else                       return w;
`else
        return w;
`endif
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic fill_pattern();
        for (int s = 0; s < NMCU; s++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    mem[s][r][c] = 32'(s * 64 + r * 8 + c);
    endtask

    task automatic fill_random();
        for (int s = 0; s < NMCU; s++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    mem[s][r][c] = $urandom;
    endtask

    // Expected frame in image raster order, straight from the image layout.
    task automatic push_frame();
        pix_t e;
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                e.d   = exp_word(mem[(yy / 8) * COLS + xx / 8][yy % 8][xx % 8]);
                e.x   = 16'(xx);
                e.y   = 16'(yy);
                e.sof = (xx == 0) && (yy == 0);
                e.eol = (xx == W - 1);
                e.eof = (xx == W - 1) && (yy == H - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic kick();
        push_frame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_acc(input int target);
        int n;
        n = 0;
        while (acc < target && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check("acc_reach", 64'(acc >= target), 64'd1);
    endtask

    task automatic run_frame(input bit chk, input int busy_start_at);
        int  cyc;
        int  a0;
        bit  got;
        bit  pulsed;
        a0 = acc;
        kick();
        cyc = 1;
        if (chk) check("lat_run", {62'd0, busy, ifc.pix_valid}, 64'b10);
        got = 1'b0;
        pulsed = 1'b0;
        while (cyc < 20000) begin
            @(posedge clk);
            cyc++;
            #1;
            if (chk && cyc == 2) check("lat_first", 64'(ifc.pix_valid), 64'd1);
            start = 1'b0;
            if (busy_start_at > 0 && !pulsed && (acc - a0) >= busy_start_at) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check("done_seen", 64'(got), 64'd1);
        if (chk) check("frame_cycles", 64'(cyc), 64'(NPIX + 2));
        check("q_empty", 64'(q.size()), 64'd0);
        check("acc_count", 64'(acc - a0), 64'(NPIX));
    endtask

    // Main monitor: pops the scoreboard on every accepted pixel.
    pix_t got_p;
    pix_t held_p;
    pix_t exp_p;
    bit   stalled  = 1'b0;
    bit   exp_done = 1'b0;
    always @(negedge clk) begin
        got_p = {ifc.pix_data, ifc.pix_x, ifc.pix_y, ifc.sof, ifc.eol, ifc.eof};
        if (rst) begin
            stalled  = 1'b0;
            exp_done = 1'b0;
        end else begin
            if (exp_done) begin
                total++;
                if (!(done === 1'b1 && busy === 1'b0)) begin
                    bad++;
                    $display("FAIL done_pulse actual done=%b busy=%b expected done=1 busy=0", done, busy);
                end
                exp_done = 1'b0;
            end else if (done) begin
                total++;
                bad++;
                $display("FAIL done_unexpected actual=1 expected=0");
            end
            if (stalled) begin
                total++;
                if (ifc.pix_valid !== 1'b1 || got_p !== held_p) begin
                    bad++;
                    $display("FAIL stall_hold actual=%0h/%b expected=%0h/1", got_p, ifc.pix_valid, held_p);
                end
            end
            if (ifc.pix_valid && ifc.pix_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL pix_extra actual=%0h expected=none", got_p);
                end else begin
                    exp_p = q.pop_front();
                    if (got_p !== exp_p) begin
                        bad++;
                        $display("FAIL pix_seq actual=%0h expected=%0h", got_p, exp_p);
                    end
                end
                acc++;
                if (ifc.eof) exp_done = 1'b1;
            end
            stalled = ifc.pix_valid && !ifc.pix_ready;
            held_p  = got_p;
        end
    end

    // Small-instance monitor (consumer always ready).
    pix_t got2;
    pix_t exp2;
    always @(negedge clk) begin
        if (!rst && ifc2.pix_valid && ifc2.pix_ready) begin
            got2 = {ifc2.pix_data, ifc2.pix_x, ifc2.pix_y, ifc2.sof, ifc2.eol, ifc2.eof};
            total++;
            if (q2.size() == 0) begin
                bad++;
                $display("FAIL pix2_extra actual=%0h expected=none", got2);
            end else begin
                exp2 = q2.pop_front();
                if (got2 !== exp2) begin
                    bad++;
                    $display("FAIL pix2_seq actual=%0h expected=%0h", got2, exp2);
                end
            end
        end
    end

    task automatic run_small();
        pix_t e;
        int   cyc;
        bit   got;
        for (int s = 0; s < COLS2 * ROWS2; s++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    mem2[s][r][c] = 32'(s * 64 + r * 8 + c);
        for (int yy = 0; yy < 8 * ROWS2; yy++) begin
            for (int xx = 0; xx < 8 * COLS2; xx++) begin
                e.d   = exp_word(32'(((yy / 8) * COLS2 + xx / 8) * 64 + (yy % 8) * 8 + xx % 8));
                e.x   = 16'(xx);
                e.y   = 16'(yy);
                e.sof = (xx == 0) && (yy == 0);
                e.eol = (xx == 8 * COLS2 - 1);
                e.eof = (xx == 8 * COLS2 - 1) && (yy == 8 * ROWS2 - 1);
                q2.push_back(e);
            end
        end
        @(posedge clk); #1 start2 = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (cyc < 5000) begin
            @(posedge clk);
            cyc++;
            #1 start2 = 1'b0;
            if (done2) begin
                got = 1'b1;
                break;
            end
        end
        check("small_done", 64'(got), 64'd1);
        check("small_cycles", 64'(cyc), 64'(64 * COLS2 * ROWS2 + 2));
        check("small_q_empty", 64'(q2.size()), 64'd0);
    endtask

    initial begin
        fill_pattern();
        for (int s = 0; s < COLS2 * ROWS2; s++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    mem2[s][r][c] = '0;

        // Reset state.
        #1;
        check("rst0_data", 64'(ifc.pix_data), 64'd0);
        check("rst0_ctl", {58'd0, ifc.pix_valid, ifc.sof, ifc.eol, ifc.eof, busy, done}, 64'd0);
        check("rst0_sel", {42'd0, sel, sel2}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Full frame, no backpressure: latency, throughput, pattern values.
        bp_en = 1'b0;
        run_frame(1'b1, 0);

        // Same frame under random backpressure, with a start pulse while busy.
        bp_en = 1'b1;
        run_frame(1'b0, 200);
        repeat (10) @(posedge clk);
        #1;
        check("post_frame_idle", {62'd0, busy, ifc.pix_valid}, 64'd0);
        check("post_frame_q", 64'(q.size()), 64'd0);

        // Random MCU contents under backpressure.
        fill_random();
        run_frame(1'b0, 0);

        // Abort at pixel 100.
        fill_pattern();
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        begin
            int a0;
            a0 = acc;
            kick();
            wait_acc(a0 + 100);
        end
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("abort_clear", {62'd0, busy, ifc.pix_valid}, 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_sel", 64'(sel), 64'd0);
        q.delete();

        // start and abort together in IDLE.
        @(posedge clk); #1 begin start = 1'b1; abort = 1'b1; end
        @(posedge clk); #1 begin start = 1'b0; abort = 1'b0; end
        check("start_abort_idle", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("start_abort_idle2", {62'd0, busy, ifc.pix_valid}, 64'd0);

        // Asynchronous reset mid-frame at pixel 500.
        bp_en = 1'b1;
        begin
            int a0;
            a0 = acc;
            kick();
            wait_acc(a0 + 500);
        end
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("rst_mid_data", 64'(ifc.pix_data), 64'd0);
        check("rst_mid_pos", {32'd0, ifc.pix_x, ifc.pix_y}, 64'd0);
        check("rst_mid_ctl", {58'd0, ifc.pix_valid, ifc.sof, ifc.eol, ifc.eof, busy, done}, 64'd0);
        check("rst_mid_sel", 64'(sel), 64'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bp_en = 1'b0;
        run_frame(1'b1, 0);

        // Clamp corner values at the first three pixels.
        mem[0][0][0] = 32'hFFFF_FFFB;
        mem[0][0][1] = 32'd300;
        mem[0][0][2] = 32'd77;
        run_frame(1'b1, 0);

        // 2x2 MCU instance: row 8 starts in MCU 2, eof pixel in MCU 3.
        run_small();

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
